// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// MEM stage of the 5-stage LoongArch pipeline, sitting between EX and WB.
// It holds one instruction at a time. On a load it waits for the data-SRAM
// response, then extracts and extends the load data. It passes the final
// result to WB through a valid/allowin handshake. It also reports its
// contents back to decode so that decode can forward results and stall on
// load-use.
//
// Build option:
//   MS_SUBWORD_LOAD_EN  defined   -> byte/half loads (signed and unsigned)
//                                    are extracted from the response word
//                                    using the low address bits.
//                       undefined -> every load returns the raw response
//                                    word, and no extraction logic is built.
//
// Ports:
//   clk                in   1   core clock
//   reset              in   1   synchronous, active-high reset
//   ms_allowin         out  1   MS can take an instruction from EX this cycle
//   es_to_ms_valid     in   1   EX is presenting a valid instruction
//   es_to_ms_bus       in   74  {load_op[73:71], res_from_mem[70], gr_we[69],
//                               dest[68:64], alu_result[63:32], pc[31:0]}
//   ws_allowin         in   1   WB can accept an instruction
//   ms_to_ws_valid     out  1   MS output to WB is valid
//   ms_to_ws_bus       out  70  {gr_we[69], dest[68:64], final_result[63:32],
//                               pc[31:0]}
//   data_sram_data_ok  in   1   load response strobe, one per load issued
//   data_sram_rdata    in   32  load response data
//   ms_forward         out  40  {load_pending[39], final_result[38:7],
//                               dest[6:2], gr_we[1], ms_valid[0]}
// ---------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [73:0] es_to_ms_bus,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic [39:0] ms_forward
);

    localparam int ES_TO_MS_BUS_WD = 74;

    logic                       ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
    logic                       ms_ready_go;

    logic                       data_buf_valid;
    logic [31:0]                data_buf;

    logic [31:0] ms_pc;
    logic [31:0] alu_result;
    logic [4:0]  dest;
    logic        gr_we;
    logic        res_from_mem;
    logic [2:0]  load_op;

    logic [31:0] mem_word;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic        load_pending;

    assign ms_pc        = es_to_ms_bus_r[31:0];
    assign alu_result   = es_to_ms_bus_r[63:32];
    assign dest         = es_to_ms_bus_r[68:64];
    assign gr_we        = es_to_ms_bus_r[69];
    assign res_from_mem = es_to_ms_bus_r[70];
    assign load_op      = es_to_ms_bus_r[73:71];

    // A load may leave only once its data exists, either arriving live this
    // cycle or already parked in the response buffer.
    assign ms_ready_go    = !res_from_mem || data_sram_data_ok || data_buf_valid;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    // Valid bit and payload register. The payload is not reset because it
    // is meaningless while ms_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
        if (es_to_ms_valid && ms_allowin) begin
            es_to_ms_bus_r <= es_to_ms_bus;
        end
    end

    // The SRAM strobes data_ok for one cycle only. If WB is stalled at that
    // moment the word would be lost, so it is parked here until the load
    // leaves. Leaving takes priority, so a new instruction that enters on
    // the same edge starts with an empty buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_buf_valid <= 1'b0;
            data_buf       <= 32'h0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            data_buf_valid <= 1'b0;
        end else if (ms_valid && res_from_mem && data_sram_data_ok &&
                     !ws_allowin && !data_buf_valid) begin
            data_buf_valid <= 1'b1;
            data_buf       <= data_sram_rdata;
        end
    end

    // The parked word takes priority, because the live rdata may already
    // belong to a later transaction.
    assign mem_word = data_buf_valid ? data_buf : data_sram_rdata;

`ifdef MS_SUBWORD_LOAD_EN
    logic [1:0]  byte_addr;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign byte_addr = alu_result[1:0];

    // Select the addressed byte or half-word, then sign- or zero-extend it
    // according to load_op. For half-words only addr[1] is used. The
    // unused encodings 5..7 fall back to a full-word load.
    always_comb begin
        load_byte = 8'h0;
        case (byte_addr)
            2'd0:    load_byte = mem_word[7:0];
            2'd1:    load_byte = mem_word[15:8];
            2'd2:    load_byte = mem_word[23:16];
            default: load_byte = mem_word[31:24];
        endcase
        load_half = byte_addr[1] ? mem_word[31:16] : mem_word[15:0];

        load_data = mem_word;
        case (load_op)
            3'd1:    load_data = {{24{load_byte[7]}}, load_byte};
            3'd2:    load_data = {{16{load_half[15]}}, load_half};
            3'd3:    load_data = {24'h0, load_byte};
            3'd4:    load_data = {16'h0, load_half};
            default: load_data = mem_word;
        endcase
    end
`else
    logic unused_load_op;

    // Without sub-word support every load is a full word, so load_op has
    // no effect in this build.
    assign unused_load_op = ^load_op;
    assign load_data      = mem_word;
`endif

    assign final_result = res_from_mem ? load_data : alu_result;

    // Decode must stall a dependent instruction while the load result is
    // still outstanding.
    assign load_pending = ms_valid && res_from_mem && !ms_ready_go;

    assign ms_to_ws_bus = {gr_we, dest, final_result, ms_pc};
    assign ms_forward   = {load_pending, final_result, dest, gr_we, ms_valid};

endmodule
